// File: rtl/adder_serial_n.sv
// Digit-serial WIDTH-bit adder/subtractor. One N-bit slice adder is reused over
// WIDTH/N clocks, least-significant slice first, with the slice carry held in a
// register between clocks. Start/Busy/Done handshake; results update only when
// the last slice completes.
module adder_serial_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int STEPS  = WIDTH / N;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  generate
    if (WIDTH % N != 0) begin : g_bad_slice
      $error("adder_serial_n: WIDTH (%0d) must be a multiple of N (%0d)", WIDTH, N);
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_last;

  logic [STEP_W-1:0] r_step;
  logic              r_carry;
  logic              r_done;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  // Operand and partial-result storage; pure data, no reset needed.
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res;

  logic [N-1:0]      w_a_slice;
  logic [N-1:0]      w_b_slice;
  logic [N:0]        w_slice_sum;
  logic [WIDTH-1:0]  w_full;

  // State register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state: accept Start only when idle; leave RUN on the final slice.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (r_step == LAST_STEP) begin
          w_last = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Slice adder (N+1 bits) and the result with the current slice merged in,
  // so the completing edge can publish the whole word at once.
  always_comb begin
    int lsb;
    lsb         = int'(r_step) * N;
    w_a_slice   = r_a[lsb +: N];
    w_b_slice   = r_b[lsb +: N];
    w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{N{1'b0}}, r_carry};
    w_full      = r_res;
    w_full[lsb +: N] = w_slice_sum[N-1:0];
  end

  // Control and visible results: step counter, carry, Done pulse, Sum/Cout/Overflow.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_step  <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_step  <= '0;
        r_carry <= Sub ? 1'b1 : Cin;
      end else if (r_state == S_RUN) begin
        r_step  <= w_last ? '0 : r_step + STEP_W'(1);
        r_carry <= w_slice_sum[N];
      end
      if (w_last) begin
        r_sum  <= w_full;
        r_cout <= w_slice_sum[N];
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_full[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  // Operand capture (B inverted for subtract) and partial-result accumulation.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_a <= A;
      r_b <= Sub ? ~B : B;
    end else if (r_state == S_RUN) begin
      r_res <= w_full;
    end
  end

  assign Busy     = (r_state == S_RUN);
  assign Done     = r_done;
  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_adder_serial_n.sv
// Directed bench for adder_serial_n: WIDTH=16/N=4 main instance plus an N=16 build.
module tb_adder_serial_n;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        Start;
  logic        Start16;
  logic        Sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;

  logic        Busy, Done, Cout, Overflow;
  logic [15:0] Sum;
  logic        Busy16, Done16, Cout16, Overflow16;
  logic [15:0] Sum16;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  adder_serial_n #(.WIDTH(16), .N(4)) dut (
    .CLK(CLK), .nRESET(nRESET), .Start(Start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
  );

  adder_serial_n #(.WIDTH(16), .N(16)) dut16 (
    .CLK(CLK), .nRESET(nRESET), .Start(Start16), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy16), .Done(Done16), .Sum(Sum16), .Cout(Cout16), .Overflow(Overflow16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with Start for exactly one rising edge (E0), return #1 after it.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  // From #1 after E0, count edges until Done is seen (bounded) and Busy cycles.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!Done && edges < 20) begin
      if (Busy) busy_cycles++;
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub, input logic [15:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
    int edges, bc;
    start_op(a, b, cin, sub);
    wait_done(edges, bc);
    check({tag, "_latency"}, edges, 4);
    check({tag, "_sum"}, {16'h0, Sum}, {16'h0, exp_sum});
    check({tag, "_cout"}, {31'h0, Cout}, {31'h0, exp_cout});
    check({tag, "_ovf"}, {31'h0, Overflow}, {31'h0, exp_ovf});
  endtask

  initial begin
    int edges, bc;
    nRESET = 1'b0; Start = 1'b0; Start16 = 1'b0; Sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", {31'h0, Busy}, 0);
    check("rst_done", {31'h0, Done}, 0);
    check("rst_sum",  {16'h0, Sum}, 0);
    check("rst_cout", {31'h0, Cout}, 0);
    check("rst_ovf",  {31'h0, Overflow}, 0);
    nRESET = 1'b1;
    @(posedge CLK); #1;

    // Basic add with Busy profile
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("t1_busy_after_e0", {31'h0, Busy}, 1);
    wait_done(edges, bc);
    check("t1_latency", edges, 4);
    check("t1_busy_cycles", bc, 4);
    check("t1_busy_at_done", {31'h0, Busy}, 0);
    check("t1_sum", {16'h0, Sum}, 32'h2233);
    check("t1_cout", {31'h0, Cout}, 0);
    check("t1_ovf", {31'h0, Overflow}, 0);
    @(posedge CLK); #1;
    check("t1_done_one_cycle", {31'h0, Done}, 0);
    check("t1_sum_held", {16'h0, Sum}, 32'h2233);

    run_and_check("t2_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_and_check("t2_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_and_check("t3_posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_and_check("t3_negovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_and_check("t4_sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_and_check("t4_sub_eq",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Start while busy is ignored; Start in the Done cycle is accepted
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge CLK); #1;
    A = 16'hAAAA; B = 16'hAAAA; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; A = '0; B = '0;
    check("t5_sum_not_partial", {16'h0, Sum}, 32'h0000);
    wait_done(edges, bc);
    check("t5_ignored_latency", edges, 2);
    check("t5_ignored_sum", {16'h0, Sum}, 32'h3333);
    check("t5_ignored_cout", {31'h0, Cout}, 0);
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    check("t5_b2b_busy", {31'h0, Busy}, 1);
    check("t5_b2b_sum_held", {16'h0, Sum}, 32'h3333);
    wait_done(edges, bc);
    check("t5_b2b_latency", edges, 4);
    check("t5_b2b_sum", {16'h0, Sum}, 32'h0003);
    @(posedge CLK); #1;
    check("t5_no_extra_done", {31'h0, Done}, 0);

    // Reset mid-operation: previous results nonzero, reset clears immediately
    start_op(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    @(posedge CLK); #1;
    nRESET = 1'b0;
    #1;
    check("t6_rst_busy", {31'h0, Busy}, 0);
    check("t6_rst_done", {31'h0, Done}, 0);
    check("t6_rst_sum",  {16'h0, Sum}, 0);
    check("t6_rst_cout", {31'h0, Cout}, 0);
    check("t6_rst_ovf",  {31'h0, Overflow}, 0);
    @(posedge CLK); #1;
    nRESET = 1'b1;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (Done || Busy) bc++;
    end
    check("t6_no_done_after_release", bc, 0);

    // N=16 build: single-edge latency
    A = 16'h1234; B = 16'h0FFF; Cin = 1'b0; Sub = 1'b0; Start16 = 1'b1;
    @(posedge CLK); #1;
    Start16 = 1'b0;
    check("t6_n16_busy", {31'h0, Busy16}, 1);
    edges = 0;
    while (!Done16 && edges < 20) begin
      @(posedge CLK); #1;
      edges++;
    end
    check("t6_n16_latency", edges, 1);
    check("t6_n16_sum", {16'h0, Sum16}, 32'h2233);
    check("t6_n16_cout", {31'h0, Cout16}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
